// File: rtl/cnt_day.sv
// Day-of-month counter (leap-aware), 1-cycle latency from pulse_1d/button edge to cnt_d.
// No backpressure: pulse_1mo is a combinational same-cycle strobe to the month counter.
module cnt_day (
    input  logic        clk,
    input  logic        rst,
    input  logic        pulse_1d,
    input  logic        increase_d,
    input  logic        decrease_d,
    input  logic        enable_cnt_d,
    input  logic [5:0]  cnt_mo,
    input  logic [11:0] cnt_y,
    output logic [5:0]  cnt_d,
    output logic        pulse_1mo
);

    logic [5:0] cnt, cnt_nxt;
    logic       pre_inc, pre_inc_nxt;
    logic       pre_dec, pre_dec_nxt;
    logic       leap;
    logic [5:0] dim;
    logic       btn_act;

    assign leap = ((cnt_y[1:0] == 2'b00) && ((cnt_y % 12'd100) != 12'd0)) ||
                  ((cnt_y % 12'd400) == 12'd0);

    always_comb begin
        dim = 6'd31;
        case (cnt_mo)
            6'd4, 6'd6, 6'd9, 6'd11: dim = 6'd30;
            6'd2:                    dim = leap ? 6'd29 : 6'd28;
            default:                 dim = 6'd31;
        endcase
    end

    always_comb begin
        cnt_nxt     = cnt;
        pre_inc_nxt = pre_inc;
        pre_dec_nxt = pre_dec;
        btn_act     = 1'b0;
        if (enable_cnt_d) begin
            // Increase wins; a coincident decrease edge stays pending in pre_dec.
            if (increase_d != pre_inc) begin
                pre_inc_nxt = increase_d;
                if (!increase_d) begin
                    btn_act = 1'b1;
                    cnt_nxt = (cnt == dim) ? 6'd1 : cnt + 6'd1;
                end
            end else if (decrease_d != pre_dec) begin
                pre_dec_nxt = decrease_d;
                if (!decrease_d) begin
                    btn_act = 1'b1;
                    cnt_nxt = (cnt == 6'd1) ? dim : cnt - 6'd1;
                end
            end
            if (!btn_act && pulse_1d)
                cnt_nxt = (cnt == dim) ? 6'd1 : cnt + 6'd1;
        end
        // Clamp after a month/year change overrides any step but not edge tracking.
        if (cnt > dim)
            cnt_nxt = dim;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= 6'd1;
            pre_inc <= 1'b1;
            pre_dec <= 1'b1;
        end else begin
            cnt     <= cnt_nxt;
            pre_inc <= pre_inc_nxt;
            pre_dec <= pre_dec_nxt;
        end
    end

    assign pulse_1mo = enable_cnt_d & pulse_1d & (cnt == dim);
    assign cnt_d     = cnt;

endmodule
